// File: rtl/enigma_tx_formatter.sv
// ---------------------------------------------------------------------------
// enigma_tx_formatter
//
// Output stage behind the enigma core. Each ciphertext letter the core strobes
// out is captured into a small FIFO. The letters are then sent to the UART
// transmitter as five-letter groups separated by spaces, with CR LF line
// breaks. A flush request ends the current line once the buffered letters
// have been sent.
//
// Optional feature macro: ENIGMA_FMT_PAD_EN
//   defined   : a flush that lands inside a partial group first pads the group
//               with 'X' up to GROUP_LEN, then sends CR LF.
//   undefined : the PAD state does not exist, and a flush sends CR LF right
//               after the last real letter.
//
// Parameters
//   FIFO_DEPTH      letter buffer depth, power of two, 4..64
//   GROUP_LEN       letters per group, 1..15
//   GROUPS_PER_LINE groups per line before CR LF, 1..15
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   in_char       in   8-bit ASCII letter from the core
//   in_char_ready in   one-cycle strobe, in_char valid
//   flush         in   one-cycle request to terminate the current line
//   tx_busy       in   UART transmitter busy
//   tx_data       out  byte to transmit, valid while tx_start=1
//   tx_start      out  one-cycle transmit request
//   overflow      out  sticky, a letter was dropped because the FIFO was full
//   fifo_level    out  number of letters currently buffered
// ---------------------------------------------------------------------------
module enigma_tx_formatter #(
  parameter int FIFO_DEPTH      = 16,
  parameter int GROUP_LEN       = 5,
  parameter int GROUPS_PER_LINE = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_char,
  input  logic                          in_char_ready,
  input  logic                          flush,
  input  logic                          tx_busy,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [AW:0]   LEVEL_ZERO = {(AW + 1){1'b0}};
  localparam logic [AW:0]   LEVEL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LEVEL_FULL = FIFO_DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [3:0]    GRP_FULL   = GROUP_LEN[3:0];
  localparam logic [3:0]    LAST_GRP   = 4'(GROUPS_PER_LINE - 1);

  localparam logic [7:0] BYTE_SPACE = 8'h20;
  localparam logic [7:0] BYTE_CR    = 8'h0D;
  localparam logic [7:0] BYTE_LF    = 8'h0A;
`ifdef ENIGMA_FMT_PAD_EN
  localparam logic [7:0] BYTE_PAD   = 8'h58;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHAR = 3'd1,
    S_SEP  = 3'd2,
    S_CR   = 3'd3,
    S_LF   = 3'd4,
`ifdef ENIGMA_FMT_PAD_EN
    S_PAD  = 3'd5,
`endif
    S_WAIT = 3'd6
  } state_t;

  // Only upper-case letters are worth transmitting.
  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  state_t          state;
  state_t          ret_state;     // where WAIT goes once the UART is free
  logic            wait_first;    // first WAIT cycle, when tx_busy is ignored
  logic [3:0]      grp_cnt;       // letters sent in the current group
  logic [3:0]      line_grp;      // completed groups in the current line
  logic            flush_pending;
  logic            flush_ctx;     // the line end in progress was caused by a flush

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  logic            fifo_empty;
  logic            fifo_full;
  logic            letter_in;
  logic            push;
  logic            pop;
  logic            drop;
  logic [7:0]      head;

  assign fifo_level = count;
  assign head       = mem[rd_ptr];

  // FIFO status and push/pop/drop decisions. A pop in the same cycle frees
  // a slot, so a write at full is still accepted then.
  always_comb begin
    fifo_empty = (count == LEVEL_ZERO);
    fifo_full  = (count == LEVEL_FULL);
    letter_in  = in_char_ready && is_upper(in_char);
    pop        = (state == S_CHAR) && !tx_busy;
    push       = letter_in && (!fifo_full || pop);
    drop       = letter_in && fifo_full && !pop;
  end

  // Letter storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_char;
    end
  end

  // FIFO pointers, fill level and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= PTR_ZERO;
      rd_ptr   <= PTR_ZERO;
      count    <= LEVEL_ZERO;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + LEVEL_ONE;
        2'b01:   count <= count - LEVEL_ONE;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Formatting FSM: picks the next byte, handshakes with the UART and keeps
  // the group/line counters. Separators are emitted lazily, just before the
  // letter that follows them, so a line never ends in a space.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ret_state     <= S_IDLE;
      wait_first    <= 1'b0;
      grp_cnt       <= 4'd0;
      line_grp      <= 4'd0;
      flush_pending <= 1'b0;
      flush_ctx     <= 1'b0;
      tx_data       <= 8'h00;
      tx_start      <= 1'b0;
    end else begin
      tx_start <= 1'b0;

      case (state)
        S_IDLE: begin
          if (flush_pending && fifo_empty) begin
            if ((grp_cnt != 4'd0) || (line_grp != 4'd0)) begin
              flush_ctx <= 1'b1;
`ifdef ENIGMA_FMT_PAD_EN
              if ((grp_cnt != 4'd0) && (grp_cnt < GRP_FULL)) begin
                state <= S_PAD;
              end else begin
                state <= S_CR;
              end
`else
              state <= S_CR;
`endif
            end else begin
              // Nothing on the line: the flush is satisfied silently.
              flush_pending <= 1'b0;
            end
          end else if (!fifo_empty) begin
            flush_ctx <= 1'b0;
            if ((grp_cnt == GRP_FULL) && (line_grp == LAST_GRP)) begin
              state <= S_CR;
            end else if (grp_cnt == GRP_FULL) begin
              state <= S_SEP;
            end else begin
              state <= S_CHAR;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_CHAR: begin
          if (!tx_busy) begin
            tx_data    <= head;
            tx_start   <= 1'b1;
            grp_cnt    <= grp_cnt + 4'd1;
            ret_state  <= S_IDLE;
            wait_first <= 1'b1;
            state      <= S_WAIT;
          end else begin
            state <= S_CHAR;
          end
        end

        S_SEP: begin
          if (!tx_busy) begin
            tx_data    <= BYTE_SPACE;
            tx_start   <= 1'b1;
            grp_cnt    <= 4'd0;
            line_grp   <= line_grp + 4'd1;
            ret_state  <= S_IDLE;
            wait_first <= 1'b1;
            state      <= S_WAIT;
          end else begin
            state <= S_SEP;
          end
        end

`ifdef ENIGMA_FMT_PAD_EN
        S_PAD: begin
          if (!tx_busy) begin
            tx_data    <= BYTE_PAD;
            tx_start   <= 1'b1;
            grp_cnt    <= grp_cnt + 4'd1;
            // The pad that completes the group hands over to CR.
            ret_state  <= ((grp_cnt + 4'd1) == GRP_FULL) ? S_CR : S_PAD;
            wait_first <= 1'b1;
            state      <= S_WAIT;
          end else begin
            state <= S_PAD;
          end
        end
`endif

        S_CR: begin
          if (!tx_busy) begin
            tx_data    <= BYTE_CR;
            tx_start   <= 1'b1;
            grp_cnt    <= 4'd0;
            line_grp   <= 4'd0;
            ret_state  <= S_LF;
            wait_first <= 1'b1;
            state      <= S_WAIT;
          end else begin
            state <= S_CR;
          end
        end

        S_LF: begin
          if (!tx_busy) begin
            tx_data    <= BYTE_LF;
            tx_start   <= 1'b1;
            ret_state  <= S_IDLE;
            wait_first <= 1'b1;
            state      <= S_WAIT;
            // A line break forced by a full line leaves a pending flush alone.
            if (flush_ctx) begin
              flush_pending <= 1'b0;
              flush_ctx     <= 1'b0;
            end
          end else begin
            state <= S_LF;
          end
        end

        S_WAIT: begin
          // The UART raises busy a cycle after tx_start, so the first
          // cycle here must not trust tx_busy.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!tx_busy) begin
            state <= ret_state;
          end else begin
            state <= S_WAIT;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      // A new request always wins over a same-cycle clear; repeats merge.
      if (flush) begin
        flush_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_enigma_tx_formatter.sv
module tb_enigma_tx_formatter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_char;
  logic       in_char_ready;
  logic       flush;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       overflow;
  logic [4:0] fifo_level;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap [$];
  int         base = 0;
  int         busy_len = 0;
  int         busy_cnt = 0;
  logic       hold_busy = 1'b0;
  logic       prev_start = 1'b0;

  enigma_tx_formatter #(
    .FIFO_DEPTH(16),
    .GROUP_LEN(5),
    .GROUPS_PER_LINE(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_char(in_char),
    .in_char_ready(in_char_ready),
    .flush(flush),
    .tx_busy(tx_busy),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  assign tx_busy = hold_busy | (busy_cnt != 0);

  // UART model: samples tx_start on the falling edge, records the byte and
  // stays busy for busy_len cycles.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt   = 0;
      prev_start = 1'b0;
    end else begin
      if (tx_start) begin
        checks = checks + 1;
        assert (prev_start === 1'b0) else begin
          errors = errors + 1;
          $error("FAIL tx_start_consecutive observed %b expected 0", prev_start);
        end
        cap.push_back(tx_data);
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
      end
      prev_start = tx_start;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    hold_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = cap.size();
  endtask

  task automatic feed(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      in_char = s[i];
      in_char_ready = 1'b1;
      @(negedge clk);
      in_char_ready = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int cnt;
    cnt = 0;
    while ((cap.size() < base + n) && (cnt < 3000)) begin
      @(negedge clk);
      cnt++;
    end
    checks = checks + 1;
    assert ((cap.size() >= base + n) === 1'b1) else begin
      errors = errors + 1;
      $error("FAIL %s_timeout observed %0d bytes expected %0d", tag, cap.size() - base, n);
    end
  endtask

  task automatic check_stream(input string tag, input string exp);
    logic [7:0] e;
    repeat (40) @(negedge clk);
    checks = checks + 1;
    assert ((cap.size() - base) === exp.len()) else begin
      errors = errors + 1;
      $error("FAIL %s_len observed %0d expected %0d", tag, cap.size() - base, exp.len());
    end
    for (int i = 0; (i < exp.len()) && (base + i < cap.size()); i++) begin
      e = exp[i];
      checks = checks + 1;
      assert (cap[base + i] === e) else begin
        errors = errors + 1;
        $error("FAIL %s_byte%0d observed %h expected %h", tag, i, cap[base + i], e);
      end
    end
    base = cap.size();
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    string exp;
    int cnt;
    reset = 1'b1;
    in_char = 8'h00;
    in_char_ready = 1'b0;
    flush = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_val("rst_tx_data", tx_data, 8'h00);
    check_val("rst_tx_start", {7'd0, tx_start}, 8'h00);
    check_val("rst_overflow", {7'd0, overflow}, 8'h00);
    check_val("rst_fifo_level", {3'd0, fifo_level}, 8'h00);
    reset = 1'b0;
    base = cap.size();

    // Grouping with a slow UART, no trailing space
    busy_len = 10;
    feed("ABCDEFGHIJK", 0);
    wait_bytes("grp11", 13);
    check_stream("grp11", "ABCDE FGHIJ K");
    check_val("grp11_overflow", {7'd0, overflow}, 8'h00);

    // Full line, then a 31st letter forces CR LF first
    do_reset();
    busy_len = 0;
    feed("ABCDEFGHIJKLMNOPQRSTUVWXYZABCD", 6);
    wait_bytes("line30", 35);
    check_stream("line30", "ABCDE FGHIJ KLMNO PQRST UVWXY ZABCD");
    feed("E", 0);
    wait_bytes("line31", 3);
    check_stream("line31", "\015\012E");

    // Flush of a partial group, then a flush on an empty line
    do_reset();
    busy_len = 2;
    feed("ABC", 3);
    pulse_flush();
`ifdef ENIGMA_FMT_PAD_EN
    exp = "ABCXX\015\012";
`else
    exp = "ABC\015\012";
`endif
    wait_bytes("flush", exp.len());
    check_stream("flush", exp);
    pulse_flush();
    check_stream("flush_empty", "");

    // Overflow with the UART held busy
    do_reset();
    hold_busy = 1'b1;
    feed("ABCDEFGHIJKLMNOPQ", 0);
    check_val("ovf_level", {3'd0, fifo_level}, 8'd16);
    check_val("ovf_flag", {7'd0, overflow}, 8'h01);
    hold_busy = 1'b0;
    busy_len = 0;
    wait_bytes("ovf_drain", 19);
    check_stream("ovf_drain", "ABCDE FGHIJ KLMNO P");
    check_val("ovf_sticky", {7'd0, overflow}, 8'h01);

    // Non-letters are discarded; two-edge latency
    do_reset();
    busy_len = 0;
    feed("a", 0);
    check_val("lc_level", {3'd0, fifo_level}, 8'd0);
    feed("1", 0);
    check_val("digit_level", {3'd0, fifo_level}, 8'd0);
    @(negedge clk);
    in_char = 8'h5A;
    in_char_ready = 1'b1;
    @(negedge clk);
    in_char_ready = 1'b0;
    check_val("z_level", {3'd0, fifo_level}, 8'd1);
    check_val("lat_edge0", {7'd0, tx_start}, 8'h00);
    @(negedge clk);
    check_val("lat_edge1", {7'd0, tx_start}, 8'h00);
    @(negedge clk);
    check_val("lat_edge2", {7'd0, tx_start}, 8'h01);
    check_val("lat_data", tx_data, 8'h5A);
    check_stream("z_only", "Z");

    // Reset while waiting after CR
    do_reset();
    busy_len = 10;
    feed("ABC", 0);
    pulse_flush();
    cnt = 0;
    while (!((cap.size() > base) && (cap[cap.size() - 1] === 8'h0D)) && (cnt < 3000)) begin
      @(negedge clk);
      cnt++;
    end
    check_val("cr_seen", cap.size() > base ? cap[cap.size() - 1] : 8'hFF, 8'h0D);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("midrst_tx_start", {7'd0, tx_start}, 8'h00);
    check_val("midrst_tx_data", tx_data, 8'h00);
    check_val("midrst_level", {3'd0, fifo_level}, 8'd0);
    check_val("midrst_overflow", {7'd0, overflow}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
`ifdef ENIGMA_FMT_PAD_EN
    exp = "ABCXX\015";
`else
    exp = "ABC\015";
`endif
    check_stream("midrst_nolf", exp);
    feed("QRSTUV", 0);
    wait_bytes("after_rst", 7);
    check_stream("after_rst", "QRSTU V");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
